// File: rtl/fp_align_add.sv
// ---------------------------------------------------------------------------
// fp_align_add
//   First half of the FP32 add/sub datapath. It feeds the normalize stage.
//   Stage 1 unpacks both operands and applies the effective sign of B.
//   It then swaps the operands by magnitude and computes the exponent
//   difference. Stage 2 aligns the smaller mantissa and adds or subtracts
//   it. The result is the unnormalized {carry, leading-1, fraction}.
//   The two stages form a valid/ready pipeline with full backpressure.
//   in_ready is combinational from out_ready; there is no skid buffer.
//
//   Optional feature macro: FP_ALIGN_SPECIAL_EN
//     defined   : NaN/Inf/zero classification drives 'special'
//     undefined : 'special' is tied to 2'b00 and exp==FF is an ordinary number
//
// Ports
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   in_valid     operand bundle valid
//   in_ready     stage can accept a bundle this cycle
//   op_a, op_b   FP32 operands
//   op_sub       1 = A-B, 0 = A+B
//   out_valid    result bundle valid
//   out_ready    downstream accepts the result
//   temp_frac    {7'b0, carry, leading-1, fraction[22:0]}
//   larger_exp   biased exponent of the larger-magnitude operand
//   result_sign  sign of the result
//   special      00 normal, 01 zero-forced, 10 Inf, 11 NaN
// ---------------------------------------------------------------------------
module fp_align_add #(
    parameter int MAX_SHIFT = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        op_sub,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] temp_frac,
    output logic [7:0]  larger_exp,
    output logic        result_sign,
    output logic [1:0]  special
);

    localparam logic [7:0] MAX_SHIFT_C = 8'(MAX_SHIFT);

    // ------------------------------------------------------------------
    // Handshake chain
    // ------------------------------------------------------------------
    logic s1_valid_q, s1_valid_d;
    logic s2_valid_q, s2_valid_d;
    logic s1_adv_s;
    logic s2_adv_s;

    assign s2_adv_s = !s2_valid_q || out_ready;
    assign s1_adv_s = !s1_valid_q || s2_adv_s;
    assign in_ready = s1_adv_s;

    // ------------------------------------------------------------------
    // Stage 1 combinational: unpack, effective sign, magnitude swap
    // ------------------------------------------------------------------
    logic [7:0]  ea_s, eb_s;
    logic [22:0] fa_s, fb_s;
    logic        sa_s, sb_eff_s;
    logic [23:0] ma_s, mb_s;
    logic        swap_s;
    logic [23:0] ml_s, ms_s;
    logic [7:0]  el_s, es_s;
    logic        sl_s;
    logic        eff_sub_s;
    logic        both_zero_s;

    assign ea_s        = op_a[30:23];
    assign eb_s        = op_b[30:23];
    assign fa_s        = op_a[22:0];
    assign fb_s        = op_b[22:0];
    assign sa_s        = op_a[31];
    assign sb_eff_s    = op_b[31] ^ op_sub;
    assign eff_sub_s   = sa_s ^ sb_eff_s;
    assign swap_s      = (op_b[30:0] > op_a[30:0]);
    assign both_zero_s = (ea_s == 8'd0) && (eb_s == 8'd0);

    // Unpack mantissas; a zero exponent flushes the operand to zero
    always_comb begin
        ma_s = 24'd0;
        mb_s = 24'd0;
        if (ea_s == 8'd0) begin
            ma_s = 24'd0;
        end else begin
            ma_s = {1'b1, fa_s};
        end
        if (eb_s == 8'd0) begin
            mb_s = 24'd0;
        end else begin
            mb_s = {1'b1, fb_s};
        end
    end

    // Route the larger magnitude to L and the smaller to S
    always_comb begin
        ml_s = ma_s;
        ms_s = mb_s;
        el_s = ea_s;
        es_s = eb_s;
        sl_s = sa_s;
        if (swap_s) begin
            ml_s = mb_s;
            ms_s = ma_s;
            el_s = eb_s;
            es_s = ea_s;
            sl_s = sb_eff_s;
        end else begin
            ml_s = ma_s;
            ms_s = mb_s;
            el_s = ea_s;
            es_s = eb_s;
            sl_s = sa_s;
        end
    end

`ifdef FP_ALIGN_SPECIAL_EN
    logic a_nan_s, b_nan_s, a_inf_s, b_inf_s;
    logic cls_nan_s, cls_inf_s, cls_inf_sign_s, cls_zero_in_s;

    assign a_nan_s        = (ea_s == 8'hFF) && (fa_s != 23'd0);
    assign b_nan_s        = (eb_s == 8'hFF) && (fb_s != 23'd0);
    assign a_inf_s        = (ea_s == 8'hFF) && (fa_s == 23'd0);
    assign b_inf_s        = (eb_s == 8'hFF) && (fb_s == 23'd0);
    // Inf - Inf under effective subtraction has no defined value
    assign cls_nan_s      = a_nan_s || b_nan_s || (a_inf_s && b_inf_s && eff_sub_s);
    assign cls_inf_s      = a_inf_s || b_inf_s;
    // With both infinite and not NaN, the two signs agree
    assign cls_inf_sign_s = a_inf_s ? sa_s : sb_eff_s;
    assign cls_zero_in_s  = (ea_s == 8'd0) || (eb_s == 8'd0);
`endif

    // ------------------------------------------------------------------
    // Stage 1 registers
    // ------------------------------------------------------------------
    logic [23:0] s1_ml_q, s1_ml_d;
    logic [23:0] s1_ms_q, s1_ms_d;
    logic [7:0]  s1_el_q, s1_el_d;
    logic [7:0]  s1_dist_q, s1_dist_d;
    logic        s1_sl_q, s1_sl_d;
    logic        s1_eff_sub_q, s1_eff_sub_d;
    logic        s1_both_zero_q, s1_both_zero_d;
    logic        s1_zero_sign_q, s1_zero_sign_d;
`ifdef FP_ALIGN_SPECIAL_EN
    logic        s1_nan_q, s1_nan_d;
    logic        s1_inf_q, s1_inf_d;
    logic        s1_inf_sign_q, s1_inf_sign_d;
    logic        s1_zero_in_q, s1_zero_in_d;
`endif

    // Stage 1 next state: load a new bundle when the stage advances
    always_comb begin
        s1_valid_d     = s1_valid_q;
        s1_ml_d        = s1_ml_q;
        s1_ms_d        = s1_ms_q;
        s1_el_d        = s1_el_q;
        s1_dist_d      = s1_dist_q;
        s1_sl_d        = s1_sl_q;
        s1_eff_sub_d   = s1_eff_sub_q;
        s1_both_zero_d = s1_both_zero_q;
        s1_zero_sign_d = s1_zero_sign_q;
`ifdef FP_ALIGN_SPECIAL_EN
        s1_nan_d       = s1_nan_q;
        s1_inf_d       = s1_inf_q;
        s1_inf_sign_d  = s1_inf_sign_q;
        s1_zero_in_d   = s1_zero_in_q;
`endif
        if (s1_adv_s) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_ml_d        = ml_s;
                s1_ms_d        = ms_s;
                s1_el_d        = el_s;
                // el_s is the larger exponent, so the difference never wraps
                s1_dist_d      = el_s - es_s;
                s1_sl_d        = sl_s;
                s1_eff_sub_d   = eff_sub_s;
                s1_both_zero_d = both_zero_s;
                s1_zero_sign_d = sa_s & sb_eff_s;
`ifdef FP_ALIGN_SPECIAL_EN
                s1_nan_d       = cls_nan_s;
                s1_inf_d       = cls_inf_s;
                s1_inf_sign_d  = cls_inf_sign_s;
                s1_zero_in_d   = cls_zero_in_s;
`endif
            end else begin
                s1_ml_d = s1_ml_q;
            end
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // Stage 1 register bank
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q     <= 1'b0;
            s1_ml_q        <= 24'd0;
            s1_ms_q        <= 24'd0;
            s1_el_q        <= 8'd0;
            s1_dist_q      <= 8'd0;
            s1_sl_q        <= 1'b0;
            s1_eff_sub_q   <= 1'b0;
            s1_both_zero_q <= 1'b0;
            s1_zero_sign_q <= 1'b0;
`ifdef FP_ALIGN_SPECIAL_EN
            s1_nan_q       <= 1'b0;
            s1_inf_q       <= 1'b0;
            s1_inf_sign_q  <= 1'b0;
            s1_zero_in_q   <= 1'b0;
`endif
        end else begin
            s1_valid_q     <= s1_valid_d;
            s1_ml_q        <= s1_ml_d;
            s1_ms_q        <= s1_ms_d;
            s1_el_q        <= s1_el_d;
            s1_dist_q      <= s1_dist_d;
            s1_sl_q        <= s1_sl_d;
            s1_eff_sub_q   <= s1_eff_sub_d;
            s1_both_zero_q <= s1_both_zero_d;
            s1_zero_sign_q <= s1_zero_sign_d;
`ifdef FP_ALIGN_SPECIAL_EN
            s1_nan_q       <= s1_nan_d;
            s1_inf_q       <= s1_inf_d;
            s1_inf_sign_q  <= s1_inf_sign_d;
            s1_zero_in_q   <= s1_zero_in_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 combinational: align and add/subtract
    // ------------------------------------------------------------------
    logic [23:0] aligned_s;
    logic [24:0] sum_s;
    logic        sum_zero_s;
    logic        sign_s;

    // Truncating alignment; large distances shift everything out
    always_comb begin
        aligned_s = 24'd0;
        if (s1_dist_q >= MAX_SHIFT_C) begin
            aligned_s = 24'd0;
        end else begin
            aligned_s = s1_ms_q >> s1_dist_q;
        end
    end

    // Mantissa add/sub; L >= S, so subtraction never goes negative
    always_comb begin
        sum_s = 25'd0;
        if (s1_eff_sub_q) begin
            sum_s = {1'b0, s1_ml_q} - {1'b0, aligned_s};
        end else begin
            sum_s = {1'b0, s1_ml_q} + {1'b0, aligned_s};
        end
    end

    assign sum_zero_s = (sum_s == 25'd0);

    // Result sign: -0 + -0 stays -0, otherwise exact cancellation is +0
    always_comb begin
        sign_s = s1_sl_q;
        if (s1_both_zero_q) begin
            sign_s = s1_zero_sign_q;
        end else if (sum_zero_s) begin
            sign_s = 1'b0;
        end else begin
            sign_s = s1_sl_q;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 registers (module outputs)
    // ------------------------------------------------------------------
    logic [31:0] temp_frac_q, temp_frac_d;
    logic [7:0]  larger_exp_q, larger_exp_d;
    logic        result_sign_q, result_sign_d;
`ifdef FP_ALIGN_SPECIAL_EN
    logic [1:0]  special_q, special_d;
`endif

    // Stage 2 next state: payload only changes when the stage advances
    always_comb begin
        s2_valid_d    = s2_valid_q;
        temp_frac_d   = temp_frac_q;
        larger_exp_d  = larger_exp_q;
        result_sign_d = result_sign_q;
`ifdef FP_ALIGN_SPECIAL_EN
        special_d     = special_q;
`endif
        if (s2_adv_s) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                temp_frac_d   = {7'd0, sum_s};
                larger_exp_d  = s1_el_q;
                result_sign_d = sign_s;
`ifdef FP_ALIGN_SPECIAL_EN
                special_d     = 2'b00;
                if (s1_nan_q) begin
                    temp_frac_d   = 32'h00C0_0000;
                    larger_exp_d  = 8'hFF;
                    result_sign_d = 1'b0;
                    special_d     = 2'b11;
                end else if (s1_inf_q) begin
                    temp_frac_d   = 32'h0080_0000;
                    larger_exp_d  = 8'hFF;
                    result_sign_d = s1_inf_sign_q;
                    special_d     = 2'b10;
                end else if (s1_zero_in_q && sum_zero_s) begin
                    special_d     = 2'b01;
                end else begin
                    special_d     = 2'b00;
                end
`endif
            end else begin
                temp_frac_d = temp_frac_q;
            end
        end else begin
            s2_valid_d = s2_valid_q;
        end
    end

    // Stage 2 register bank
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q    <= 1'b0;
            temp_frac_q   <= 32'd0;
            larger_exp_q  <= 8'd0;
            result_sign_q <= 1'b0;
`ifdef FP_ALIGN_SPECIAL_EN
            special_q     <= 2'b00;
`endif
        end else begin
            s2_valid_q    <= s2_valid_d;
            temp_frac_q   <= temp_frac_d;
            larger_exp_q  <= larger_exp_d;
            result_sign_q <= result_sign_d;
`ifdef FP_ALIGN_SPECIAL_EN
            special_q     <= special_d;
`endif
        end
    end

    assign out_valid   = s2_valid_q;
    assign temp_frac   = temp_frac_q;
    assign larger_exp  = larger_exp_q;
    assign result_sign = result_sign_q;
`ifdef FP_ALIGN_SPECIAL_EN
    assign special     = special_q;
`else
    assign special     = 2'b00;
`endif

endmodule
